keypad_scanner: RTL and testbench

//  Input-side counterpart of the four-digit LED driver. Where the driver scans digit anodes

---
 rtl/keypad_pkg.sv | 38 +++
 rtl/keypad_frame_collector.sv | 102 ++++++++++
 rtl/keypad_scanner.sv | 151 +++++++++++++++
 tb/tb_keypad_scanner.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and defaults for the 4x4 matrix keypad scanner.
package keypad_pkg;

  localparam int KEY_CODE_W          = 4;
  localparam int DEF_SCAN_TICKS      = 4;
  localparam int DEF_DEBOUNCE_FRAMES = 3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_RELEASE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    FC_NONE   = 2'd0,
    FC_SINGLE = 2'd1,
    FC_MULTI  = 2'd2
  } frame_class_e;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  // Index of the single set bit; only meaningful when is_onehot4(v) holds.
  function automatic logic [1:0] enc_onehot4(input logic [3:0] v);
    logic [1:0] idx;
    case (v)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/keypad_frame_collector.sv
// Column scan sequencer: drives col_n, samples synchronised rows per column and
// classifies each complete four-column frame as NONE, SINGLE(code) or MULTI.
module keypad_frame_collector
  import keypad_pkg::*;
#(
  parameter int SCAN_TICKS = DEF_SCAN_TICKS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            row_sync_n,
  output logic [3:0]            col_n,
  output logic                  frame_end,
  output frame_class_e          frame_class,
  output logic [KEY_CODE_W-1:0] frame_code
);

  localparam int            TW        = $clog2(SCAN_TICKS);
  localparam logic [TW-1:0] LAST_TICK = TW'(SCAN_TICKS - 1);

  logic [TW-1:0]           tick_q, tick_d;
  logic [1:0]              col_idx_q, col_idx_d;
  logic [3:0]              col_n_q, col_n_d;
  frame_class_e            acc_class_q, acc_class_d;
  logic [KEY_CODE_W-1:0]   acc_code_q, acc_code_d;

  logic [3:0]              rows_low_s;
  frame_class_e            col_class_s, merged_class_s;
  logic [KEY_CODE_W-1:0]   col_code_s, merged_code_s;
  logic                    sample_s, frame_end_s;

  assign sample_s    = (tick_q == LAST_TICK);
  assign frame_end_s = sample_s && (col_idx_q == 2'd3);

  // Classify the current column and fold it into the partial frame.
  always_comb begin
    rows_low_s = ~row_sync_n;
    if (rows_low_s == 4'd0) begin
      col_class_s = FC_NONE;
    end else if (is_onehot4(rows_low_s)) begin
      col_class_s = FC_SINGLE;
    end else begin
      col_class_s = FC_MULTI;
    end
    col_code_s = {enc_onehot4(rows_low_s), col_idx_q};

    if (acc_class_q == FC_NONE) begin
      merged_class_s = col_class_s;
      merged_code_s  = col_code_s;
    end else if (col_class_s == FC_NONE) begin
      merged_class_s = acc_class_q;
      merged_code_s  = acc_code_q;
    end else begin
      merged_class_s = FC_MULTI;
      merged_code_s  = acc_code_q;
    end
  end

  // Next-state for tick/column counters and the frame accumulator.
  always_comb begin
    tick_d      = tick_q;
    col_idx_d   = col_idx_q;
    acc_class_d = acc_class_q;
    acc_code_d  = acc_code_q;
    if (sample_s) begin
      tick_d    = '0;
      col_idx_d = col_idx_q + 2'd1;
      if (frame_end_s) begin
        acc_class_d = FC_NONE;
        acc_code_d  = '0;
      end else begin
        acc_class_d = merged_class_s;
        acc_code_d  = merged_code_s;
      end
    end else begin
      tick_d = tick_q + TW'(1);
    end
    col_n_d = ~(4'b0001 << col_idx_d);
  end

  // Scan state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_q      <= '0;
      col_idx_q   <= 2'd0;
      col_n_q     <= 4'b1110;
      acc_class_q <= FC_NONE;
      acc_code_q  <= '0;
    end else begin
      tick_q      <= tick_d;
      col_idx_q   <= col_idx_d;
      col_n_q     <= col_n_d;
      acc_class_q <= acc_class_d;
      acc_code_q  <= acc_code_d;
    end
  end

  assign col_n       = col_n_q;
  assign frame_end   = frame_end_s;
  assign frame_class = merged_class_s;
  assign frame_code  = merged_code_s;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner top: row synchroniser, press/release debounce FSM and
// registered key outputs in the LED decoder's 4-bit char format.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_TICKS      = DEF_SCAN_TICKS,
  parameter int DEBOUNCE_FRAMES = DEF_DEBOUNCE_FRAMES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            row_n,
  output logic [3:0]            col_n,
  output logic [KEY_CODE_W-1:0] key_code,
  output logic                  key_valid,
  output logic                  key_held
);

  localparam int            FW        = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [FW-1:0] FCNT_DONE = FW'(DEBOUNCE_FRAMES);

  logic [3:0]              row_meta_q, row_meta_d;
  logic [3:0]              row_sync_q, row_sync_d;
  state_e                  state_q, state_d;
  logic [KEY_CODE_W-1:0]   cand_q, cand_d;
  logic [FW-1:0]           fcnt_q, fcnt_d;
  logic [KEY_CODE_W-1:0]   key_code_q, key_code_d;
  logic                    key_valid_q, key_valid_d;
  logic                    key_held_q, key_held_d;

  logic                    frame_end_s;
  frame_class_e            frame_class_s;
  logic [KEY_CODE_W-1:0]   frame_code_s;
  logic                    match_s;
  logic [FW-1:0]           fcnt_inc_s;

  keypad_frame_collector #(
    .SCAN_TICKS (SCAN_TICKS)
  ) u_collector (
    .clk         (clk),
    .reset       (reset),
    .row_sync_n  (row_sync_q),
    .col_n       (col_n),
    .frame_end   (frame_end_s),
    .frame_class (frame_class_s),
    .frame_code  (frame_code_s)
  );

  assign match_s    = (frame_class_s == FC_SINGLE) && (frame_code_s == cand_q);
  assign fcnt_inc_s = fcnt_q + FW'(1);

  // Debounce FSM; only frame-end cycles can change state.
  always_comb begin
    row_meta_d  = row_n;
    row_sync_d  = row_meta_q;
    state_d     = state_q;
    cand_d      = cand_q;
    fcnt_d      = fcnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    if (frame_end_s) begin
      case (state_q)
        ST_IDLE: begin
          if (frame_class_s == FC_SINGLE) begin
            state_d = ST_DEBOUNCE;
            cand_d  = frame_code_s;
            fcnt_d  = FW'(1);
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_DEBOUNCE: begin
          if (match_s) begin
            if (fcnt_inc_s == FCNT_DONE) begin
              state_d     = ST_PRESSED;
              fcnt_d      = '0;
              key_code_d  = cand_q;
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
            end else begin
              fcnt_d = fcnt_inc_s;
            end
          end else begin
            state_d = ST_IDLE;
            fcnt_d  = '0;
          end
        end
        ST_PRESSED: begin
          // MULTI while pressed is roll-over: keep the accepted key.
          if (match_s || (frame_class_s == FC_MULTI)) begin
            state_d = ST_PRESSED;
          end else begin
            state_d = ST_RELEASE;
            fcnt_d  = (frame_class_s == FC_NONE) ? FW'(1) : FW'(0);
          end
        end
        ST_RELEASE: begin
          if (frame_class_s == FC_NONE) begin
            if (fcnt_inc_s == FCNT_DONE) begin
              state_d    = ST_IDLE;
              fcnt_d     = '0;
              key_held_d = 1'b0;
            end else begin
              fcnt_d = fcnt_inc_s;
            end
          end else if (match_s) begin
            state_d = ST_PRESSED;
            fcnt_d  = '0;
          end else begin
            fcnt_d = '0;
          end
        end
        default: begin
          state_d    = ST_IDLE;
          fcnt_d     = '0;
          key_held_d = 1'b0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Synchroniser, FSM state and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_meta_q  <= 4'hF;
      row_sync_q  <= 4'hF;
      state_q     <= ST_IDLE;
      cand_q      <= '0;
      fcnt_q      <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      row_meta_q  <= row_meta_d;
      row_sync_q  <= row_sync_d;
      state_q     <= state_d;
      cand_q      <= cand_d;
      fcnt_q      <= fcnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a keypad model shorts pressed rows to
// their column, expected key_valid pulses (cycle and code) are queued up front.
module tb_keypad_scanner;

  logic        clk;
  logic        reset;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;

  logic [15:0] press;
  int unsigned cyc;
  int          n_checks;
  int          n_fail;

  typedef struct {
    int unsigned cyc;
    logic [3:0]  code;
  } pulse_t;

  pulse_t      sb[$];
  pulse_t      mon_p;
  logic [3:0]  mon_col;

  keypad_scanner dut (
    .clk       (clk),
    .reset     (reset),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  // Keypad model: a pressed (r,c) connects row r to column c.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (press[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
      end
    end
  end

  // Cycle index since reset release: cycle k is the period after the k-th edge.
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t cyc=%0d)", tag, got, exp, $time, cyc);
    end
  endtask

  // Column sequence and key_valid pulses checked every cycle.
  always @(negedge clk) begin
    if (reset) begin
      mon_col = ~(4'b0001 << ((cyc >> 2) & 3));
      check_eq("col_n", {28'd0, col_n}, {28'd0, mon_col});
      if (key_valid) begin
        if (sb.size() == 0) begin
          check_eq("valid_unexpected", 32'd1, 32'd0);
        end else begin
          mon_p = sb.pop_front();
          check_eq("valid_cycle", cyc, mon_p.cyc);
          check_eq("valid_code", {28'd0, key_code}, {28'd0, mon_p.code});
        end
      end
    end
  end

  task automatic frames(input int n, input logic [15:0] m);
    press = m;
    repeat (16 * n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_col_n"}, {28'd0, col_n}, 32'hE);
    check_eq({tag, "_code"}, {28'd0, key_code}, 32'h0);
    check_eq({tag, "_valid"}, {31'd0, key_valid}, 32'h0);
    check_eq({tag, "_held"}, {31'd0, key_held}, 32'h0);
  endtask

  task automatic check_state(input string tag, input logic held, input logic [3:0] code);
    check_eq({tag, "_held"}, {31'd0, key_held}, {31'd0, held});
    check_eq({tag, "_code"}, {28'd0, key_code}, {28'd0, code});
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clk);
    #2 reset = 1'b0;
    press = 16'h0000;
    #1 check_reset_values(tag);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    clk      = 1'b0;
    reset    = 1'b1;
    press    = 16'h0000;
    n_checks = 0;
    n_fail   = 0;
    #3 reset = 1'b0;
    #1 check_reset_values("por");
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Idle scan over three frames.
    frames(3, 16'h0000);
    check_state("idle", 1'b0, 4'h0);

    // Press (r2,c1) from frame 3: accepted after frame 5 ends -> cycle 96.
    sb.push_back('{cyc: 96, code: 4'h9});
    frames(6, 16'h0001 << 9);
    check_state("press_r2c1", 1'b1, 4'h9);

    // Release from frame 9: third empty frame ends at cycle 191.
    press = 16'h0000;
    repeat (47) @(posedge clk);
    @(negedge clk);
    check_eq("held_before_release", {31'd0, key_held}, 32'd1);
    @(posedge clk);
    #1;
    check_state("released", 1'b0, 4'h9);

    // Press (r1,c3) in frames 12..15: accepted at cycle 240.
    sb.push_back('{cyc: 240, code: 4'h7});
    frames(4, 16'h0001 << 7);
    check_state("press_r1c3", 1'b1, 4'h7);
    frames(4, 16'h0000);
    check_state("release_r1c3", 1'b0, 4'h7);

    // Bounce: never three consecutive matching frames.
    frames(1, 16'h0001 << 9);
    frames(1, 16'h0000);
    frames(1, 16'h0001 << 9);
    frames(2, 16'h0000);
    check_state("bounce", 1'b0, 4'h7);

    // Two keys at once from IDLE is never accepted.
    frames(5, 16'h8001);
    check_state("multi", 1'b0, 4'h7);
    frames(1, 16'h0000);

    // Reset during DEBOUNCE (one matching frame seen).
    frames(1, 16'h0001 << 9);
    pulse_reset("rst_debounce");

    // Fresh epoch: press accepted at cycle 48, then reset while PRESSED.
    sb.push_back('{cyc: 48, code: 4'h9});
    frames(4, 16'h0001 << 9);
    check_state("press_after_rst", 1'b1, 4'h9);
    pulse_reset("rst_pressed");
    frames(4, 16'h0000);
    check_state("after_rst", 1'b0, 4'h0);

    check_eq("pulses_missing", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
